// File: rtl/operand_fetch_pkg.sv
// opf_pkg: shared definitions for the operand fetch unit.
//   opf_state_e   - fetch sequencer states
//   REG_IDX_W     - register index width
//   pack_rd_addr  - builds the two-lane register-file read address
package opf_pkg;

  localparam int REG_IDX_W = 4;
  localparam int RD_ADDR_W = 10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE_A = 3'd1,
    ISSUE_B = 3'd2,
    WAIT    = 3'd3,
    CAPTURE = 3'd4,
    HOLD    = 3'd5
  } opf_state_e;

  // The register file reads each byte lane through its own 5-bit index;
  // both lanes point at the same 4-bit register here.
  function automatic logic [RD_ADDR_W-1:0] pack_rd_addr(input logic [REG_IDX_W-1:0] idx);
    return {1'b0, idx, 1'b0, idx};
  endfunction

endpackage

// File: rtl/operand_fetch_slot.sv
// operand_slot: one operand register with writeback forwarding.
//   clock, reset  - clock / async active-high reset
//   start         - request accepted this cycle (clears slot)
//   arm           - this operand is actually fetched for the request
//   start_idx     - register index presented with the request
//   cur_idx       - latched register index for the request in flight
//   capture       - rf_data carries this operand's read data this cycle
//   rf_data       - register-file read data
//   wb_en/addr/data - writeback in flight (forwarding source)
//   operand       - captured operand value
module operand_slot
  import opf_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 arm,
  input  logic [REG_IDX_W-1:0] start_idx,
  input  logic [REG_IDX_W-1:0] cur_idx,
  input  logic                 capture,
  input  logic [DATA_W-1:0]    rf_data,
  input  logic                 wb_en,
  input  logic [REG_IDX_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]    wb_data,
  output logic [DATA_W-1:0]    operand
);

  logic              pending_reg;
  logic              fwd_flag_reg;
  logic [DATA_W-1:0] fwd_val_reg;
  logic [DATA_W-1:0] operand_reg;
  logic              match_start;
  logic              match_cur;
  logic [DATA_W-1:0] capture_next;

  // In the acceptance cycle the index is not latched yet, so compare
  // against the incoming index instead.
  assign match_start = wb_en && (wb_addr == start_idx);
  assign match_cur   = wb_en && (wb_addr == cur_idx);

  // Latest writeback wins: one in the capture cycle beats an older
  // forwarded value, which in turn beats the register-file data.
  always_comb begin
    capture_next = rf_data;
    if (match_cur)
      capture_next = wb_data;
    else if (fwd_flag_reg)
      capture_next = fwd_val_reg;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending_reg  <= 1'b0;
      fwd_flag_reg <= 1'b0;
      fwd_val_reg  <= '0;
      operand_reg  <= '0;
    end else if (start) begin
      pending_reg  <= arm;
      fwd_flag_reg <= arm && match_start;
      fwd_val_reg  <= match_start ? wb_data : '0;
      operand_reg  <= '0;
    end else if (pending_reg) begin
      if (capture) begin
        operand_reg  <= capture_next;
        pending_reg  <= 1'b0;
        fwd_flag_reg <= 1'b0;
      end else if (match_cur) begin
        fwd_flag_reg <= 1'b1;
        fwd_val_reg  <= wb_data;
      end
    end
  end

  assign operand = operand_reg;

endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: fetches one or two operands from a register file with
// fixed read latency, forwarding in-flight writebacks, then holds them
// for the consumer.
//   clock, reset               - clock / async active-high reset
//   req_valid/req_ready        - request handshake
//   req_src_a/_b, req_dst      - operand indices / destination
//   req_two_op                 - 1: fetch A and B, 0: A only
//   rf_rd_en, rf_rd_addr       - register-file read port (two byte lanes)
//   rf_data                    - register-file read data
//   wb_en, wb_addr, wb_data    - writeback forwarding source
//   out_valid/out_ready        - result handshake
//   out_op_a, out_op_b, out_dst - fetched operands and destination
module operand_fetch
  import opf_pkg::*;
#(
  parameter int RD_LATENCY = 1,
  parameter int DATA_W     = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [REG_IDX_W-1:0] req_src_a,
  input  logic [REG_IDX_W-1:0] req_src_b,
  input  logic [REG_IDX_W-1:0] req_dst,
  input  logic                 req_two_op,
  output logic [1:0]           rf_rd_en,
  output logic [RD_ADDR_W-1:0] rf_rd_addr,
  input  logic [DATA_W-1:0]    rf_data,
  input  logic                 wb_en,
  input  logic [REG_IDX_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]    wb_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_op_a,
  output logic [DATA_W-1:0]    out_op_b,
  output logic [REG_IDX_W-1:0] out_dst
);

  opf_state_e           state_reg, state_next;
  logic [REG_IDX_W-1:0] src_a_reg, src_b_reg, dst_reg;
  logic                 two_op_reg;
  logic                 accept;
  logic [1:0]           issue;
  logic [1:0]           issue_d1_reg, issue_d2_reg;
  logic [1:0]           capture;

  logic [REG_IDX_W-1:0] slot_start_idx [2];
  logic [REG_IDX_W-1:0] slot_cur_idx   [2];
  logic                 slot_arm       [2];
  logic [DATA_W-1:0]    slot_operand   [2];

  assign accept = req_valid && req_ready;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_valid) state_next = ISSUE_A;
      ISSUE_A: if (two_op_reg)            state_next = ISSUE_B;
               else if (RD_LATENCY == 2)  state_next = WAIT;
               else                       state_next = CAPTURE;
      ISSUE_B: state_next = (RD_LATENCY == 2) ? WAIT : CAPTURE;
      WAIT:    state_next = CAPTURE;
      CAPTURE: state_next = HOLD;
      HOLD:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready  = (state_reg == IDLE);
    out_valid  = (state_reg == HOLD);
    rf_rd_en   = 2'b00;
    rf_rd_addr = '0;
    case (state_reg)
      ISSUE_A: begin
        rf_rd_en   = 2'b11;
        rf_rd_addr = pack_rd_addr(src_a_reg);
      end
      ISSUE_B: begin
        rf_rd_en   = 2'b11;
        rf_rd_addr = pack_rd_addr(src_b_reg);
      end
      default: ;
    endcase
  end

  // Request fields
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      src_a_reg  <= '0;
      src_b_reg  <= '0;
      dst_reg    <= '0;
      two_op_reg <= 1'b0;
    end else if (accept) begin
      src_a_reg  <= req_src_a;
      src_b_reg  <= req_src_b;
      dst_reg    <= req_dst;
      two_op_reg <= req_two_op;
    end
  end

  // Issue strobes delayed by the read latency mark the cycle in which
  // rf_data carries each operand. Clearing them on reset discards any
  // read still in flight.
  assign issue[0] = (state_reg == ISSUE_A);
  assign issue[1] = (state_reg == ISSUE_B);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      issue_d1_reg <= '0;
      issue_d2_reg <= '0;
    end else begin
      issue_d1_reg <= issue;
      issue_d2_reg <= issue_d1_reg;
    end
  end

  assign capture = (RD_LATENCY == 2) ? issue_d2_reg : issue_d1_reg;

  assign slot_start_idx[0] = req_src_a;
  assign slot_start_idx[1] = req_src_b;
  assign slot_cur_idx[0]   = src_a_reg;
  assign slot_cur_idx[1]   = src_b_reg;
  assign slot_arm[0]       = 1'b1;
  assign slot_arm[1]       = req_two_op;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
      operand_slot #(
        .DATA_W(DATA_W)
      ) u_slot (
        .clock     (clock),
        .reset     (reset),
        .start     (accept),
        .arm       (slot_arm[gi]),
        .start_idx (slot_start_idx[gi]),
        .cur_idx   (slot_cur_idx[gi]),
        .capture   (capture[gi]),
        .rf_data   (rf_data),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .operand   (slot_operand[gi])
      );
    end
  endgenerate

  assign out_op_a = slot_operand[0];
  assign out_op_b = slot_operand[1];
  assign out_dst  = dst_reg;

endmodule
